// File: rtl/button_pkg.sv
// Shared types and width helpers for the button conditioner.
package button_pkg;

    // Auto-repeat state per channel.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Bits needed to hold 0..max_val. Never returns 0, so a counter that
    // only ever holds 0 still gets a legal one-bit vector.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_if.sv
// Bundle of raw pins and conditioned strobes between the board and game logic.
interface button_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] repeat_o;
    logic            any_press_o;

    // Board / stimulus side: drives pins, consumes conditioned outputs.
    modport master (
        output btn_i,
        input  level_o, press_o, release_o, repeat_o, any_press_o
    );

    // Conditioner side.
    modport slave (
        input  btn_i,
        output level_o, press_o, release_o, repeat_o, any_press_o
    );
endinterface

// File: rtl/button_channel.sv
// One button channel: polarity fix, 2-FF sync, tick debounce, strobes, auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int ACTIVE_LOW     = 1,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_EN      = 1,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_PERIOD  = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    // The counter holds ticks already seen; the tick that completes the
    // window toggles the level directly, so it never has to reach DEBOUNCE_TICKS.
    localparam int DB_W = cnt_width(DEBOUNCE_TICKS - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            toggle;

    // Next-state for sync chain, debounce counter, level and edge strobes.
    always_comb begin
        s1_d     = btn_i ^ (ACTIVE_LOW != 0);
        s2_d     = s1_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        toggle   = 1'b0;
        if (s2_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
                toggle   = 1'b1;
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d   = toggle & ~level_q;
        release_d = toggle &  level_q;
    end

    // Register sync/debounce state; reset forces the released level without strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int RP_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD) - 1);

            rpt_state_t      state_q;
            logic [RP_W-1:0] rpt_cnt_q;
            logic            repeat_q;

            // Repeat FSM: the press tick itself is not counted, so the first
            // strobe lands exactly REPEAT_DELAY ticks after the press.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= RPT_IDLE;
                    rpt_cnt_q <= '0;
                    repeat_q  <= 1'b0;
                end else begin
                    repeat_q <= 1'b0;
                    if (release_d) begin
                        state_q   <= RPT_IDLE;
                        rpt_cnt_q <= '0;
                    end else begin
                        case (state_q)
                            RPT_IDLE: begin
                                if (press_d) begin
                                    state_q   <= RPT_DELAY;
                                    rpt_cnt_q <= '0;
                                end
                            end
                            RPT_DELAY: begin
                                if (tick) begin
                                    if (rpt_cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
                                        repeat_q  <= 1'b1;
                                        state_q   <= RPT_REPEAT;
                                        rpt_cnt_q <= '0;
                                    end else begin
                                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                                    end
                                end
                            end
                            RPT_REPEAT: begin
                                if (tick) begin
                                    if (rpt_cnt_q == RP_W'(REPEAT_PERIOD - 1)) begin
                                        repeat_q  <= 1'b1;
                                        rpt_cnt_q <= '0;
                                    end else begin
                                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                                    end
                                end
                            end
                            default: begin
                                state_q   <= RPT_IDLE;
                                rpt_cnt_q <= '0;
                            end
                        endcase
                    end
                end
            end

            assign repeat_o = repeat_q;
        end else begin : g_no_repeat
            assign repeat_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: shared tick generator plus one channel per button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int TICK_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_EN      = 1,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_PERIOD  = 50
) (
    input  logic     clk,
    input  logic     reset,
    button_if.slave  bus
);

    localparam int TK_W = cnt_width(TICK_DIV - 1);

    logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [N_CH-1:0] level_vec, press_vec, release_vec, repeat_vec;

    assign tick = (tick_cnt_q == TK_W'(TICK_DIV - 1));

    // Free-running tick divider, wraps after TICK_DIV-1.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Register the divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            button_channel #(
                .ACTIVE_LOW     (ACTIVE_LOW),
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .REPEAT_EN      (REPEAT_EN),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .tick      (tick),
                .btn_i     (bus.btn_i[gi]),
                .level_o   (level_vec[gi]),
                .press_o   (press_vec[gi]),
                .release_o (release_vec[gi]),
                .repeat_o  (repeat_vec[gi])
            );
        end
    endgenerate

    assign bus.level_o     = level_vec;
    assign bus.press_o     = press_vec;
    assign bus.release_o   = release_vec;
    assign bus.repeat_o    = repeat_vec;
    assign bus.any_press_o = |press_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (auto-repeat on / off) against a tick-arithmetic model.
module tb_button_conditioner;

    localparam int TD = 4;
    localparam int DT = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_if #(.N_CH(4)) bus_a ();
    button_if #(.N_CH(4)) bus_b ();

    assign bus_a.btn_i = btn;
    assign bus_b.btn_i = btn;

    button_conditioner #(
        .N_CH(4), .ACTIVE_LOW(1), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    button_conditioner #(
        .N_CH(4), .ACTIVE_LOW(1), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- reference model ----------------
    // k counts cycles since reset; a tick is any cycle with k % TD == TD-1.
    // A channel changes level on a tick once DT ticks have elapsed since the
    // last cycle in which the synchronised pin agreed with the level.
    // Repeats fall on ticks RD, RD+RP, RD+2RP, ... after the press tick.
    int         k;
    int         agree   [4];
    int         press_k [4];
    logic [3:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;

    function automatic bit is_tick(input int c);
        return (c % TD) == TD - 1;
    endfunction

    function automatic int ticks_upto(input int c);
        return (c + 1) / TD;
    endfunction

    function automatic bit fires(input int i);
        return (m_s2[i] != m_level[i]) && is_tick(k) &&
               (ticks_upto(k) - ticks_upto(agree[i]) == DT);
    endfunction

    function automatic bit rpt_due(input int i);
        int n;
        n = (k - press_k[i]) / TD;
        return m_level[i] && is_tick(k) && (n >= RD) && (((n - RD) % RP) == 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            k       <= 0;
            m_s1    <= '0;
            m_s2    <= '0;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_rep   <= '0;
            for (int i = 0; i < 4; i++) begin
                agree[i]   <= 0;
                press_k[i] <= 0;
            end
        end else begin
            k    <= k + 1;
            m_s1 <= ~btn;
            m_s2 <= m_s1;
            for (int i = 0; i < 4; i++) begin
                m_press[i] <= 1'b0;
                m_rel[i]   <= 1'b0;
                m_rep[i]   <= 1'b0;
                if (m_s2[i] == m_level[i]) begin
                    agree[i] <= k;
                end
                if (fires(i)) begin
                    m_level[i] <= m_s2[i];
                    agree[i]   <= k;
                    if (m_s2[i]) begin
                        m_press[i] <= 1'b1;
                        press_k[i] <= k;
                    end else begin
                        m_rel[i] <= 1'b1;
                    end
                end else if (rpt_due(i)) begin
                    m_rep[i] <= 1'b1;
                end
            end
        end
    end

    // Packed views: {level, press, release, repeat, any_press}.
    logic [16:0] act_a, act_b, exp_a, exp_b;
    assign act_a = {bus_a.level_o, bus_a.press_o, bus_a.release_o, bus_a.repeat_o, bus_a.any_press_o};
    assign act_b = {bus_b.level_o, bus_b.press_o, bus_b.release_o, bus_b.repeat_o, bus_b.any_press_o};
    assign exp_a = {m_level, m_press, m_rel, m_rep, |m_press};
    assign exp_b = {m_level, m_press, m_rel, 4'b0000, |m_press};

    // ---------------- scenarios ----------------

    // All pressed through reset, then a reset while held: outputs zero in
    // reset, no release from reset, exactly one fresh press afterwards.
    task automatic test_reset();
        int presses1, presses2, first1;
        presses1 = 0; presses2 = 0; first1 = -1;
        for (int c = 0; c < 105; c++) begin
            reset = (c < 3) || (c == 43) || (c == 44);
            btn   = (c < 85) ? 4'b0000 : 4'b1111;
            @(negedge clk);
            if (reset) begin
                n_checks++;
                if (act_a !== 17'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs c=%0d got=%h required=0", c, act_a);
                end
            end else begin
                n_checks++;
                if (act_a !== exp_a) begin
                    n_fail++;
                    $display("FAIL reset_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
                end
                n_checks++;
                if (act_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL reset_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
                end
            end
            if (bus_a.press_o == 4'b1111) begin
                if (c < 43) begin
                    presses1++;
                    if (first1 < 0) first1 = c - 3;
                end else begin
                    presses2++;
                end
            end
            if (c == 42) begin
                n_checks++;
                if (bus_a.level_o !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL reset_held_level got=%b required=1111", bus_a.level_o);
                end
            end
        end
        n_checks++;
        if (presses1 != 1 || presses2 != 1) begin
            n_fail++;
            $display("FAIL reset_press_count got=%0d,%0d required=1,1", presses1, presses2);
        end
        n_checks++;
        if (first1 < 2 + (DT - 1) * TD || first1 > 2 + (DT + 1) * TD) begin
            n_fail++;
            $display("FAIL reset_press_latency got=%0d clk required=%0d..%0d",
                     first1, 2 + (DT - 1) * TD, 2 + (DT + 1) * TD);
        end
        $display("test_reset: presses=%0d/%0d first_latency=%0d", presses1, presses2, first1);
    endtask

    // Short lows on ch0 (at most 2 ticks long) must never be accepted.
    task automatic test_glitch();
        int ln;
        for (int t = 0; t < 4; t++) begin
            ln = $urandom_range(1, 2 * TD);
            for (int c = 0; c < ln + 20; c++) begin
                btn = (c < ln) ? 4'b1110 : 4'b1111;
                @(negedge clk);
                n_checks++;
                if (act_a !== exp_a) begin
                    n_fail++;
                    $display("FAIL glitch_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
                end
                n_checks++;
                if (act_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL glitch_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
                end
                n_checks++;
                if (bus_a.level_o[0] !== 1'b0 || bus_a.press_o[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_ch0 len=%0d got level=%b press=%b required 0,0",
                             ln, bus_a.level_o[0], bus_a.press_o[0]);
                end
            end
            $display("test_glitch: ch0 low for %0d clk", ln);
        end
    endtask

    // Clean press and release on ch1 with a random hold time.
    task automatic test_clean_press();
        int hold, np, nr, rel_at;
        hold = $urandom_range(30, 50);
        np = 0; nr = 0; rel_at = -1;
        for (int c = 0; c < hold + 30; c++) begin
            btn = (c < hold) ? 4'b1101 : 4'b1111;
            @(negedge clk);
            n_checks++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL clean_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
            end
            n_checks++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL clean_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
            end
            if (bus_a.press_o[1] === 1'b1) np++;
            if (bus_a.release_o[1] === 1'b1) begin
                nr++;
                rel_at = c - hold;
            end
            if (c == hold - 1) begin
                n_checks++;
                if (bus_a.level_o[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clean_level_held got=%b required=1", bus_a.level_o[1]);
                end
            end
        end
        n_checks++;
        if (np != 1 || nr != 1) begin
            n_fail++;
            $display("FAIL clean_strobe_count got press=%0d release=%0d required 1,1", np, nr);
        end
        n_checks++;
        if (rel_at < 2 + (DT - 1) * TD || rel_at > 2 + (DT + 1) * TD) begin
            n_fail++;
            $display("FAIL clean_release_latency got=%0d clk required=%0d..%0d",
                     rel_at, 2 + (DT - 1) * TD, 2 + (DT + 1) * TD);
        end
        n_checks++;
        if (bus_a.level_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_level_final got=%b required=0", bus_a.level_o[1]);
        end
        $display("test_clean_press: hold=%0d release_latency=%0d", hold, rel_at);
    endtask

    // ch2 held ~15 ticks: repeat spacing RD ticks then RP ticks; none after release.
    // With check_b set, also verifies the repeat-disabled instance stays silent.
    task automatic test_repeat(input bit check_b);
        int hold, p_at, last_rep, nrep, nrep_late, np_b;
        bit released;
        hold = 15 * TD + $urandom_range(0, 3);
        p_at = -1; last_rep = -1; nrep = 0; nrep_late = 0; np_b = 0; released = 0;
        for (int c = 0; c < hold + 40; c++) begin
            btn = (c < hold) ? 4'b1011 : 4'b1111;
            @(negedge clk);
            n_checks++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL repeat_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
            end
            n_checks++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL repeat_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
            end
            if (bus_a.press_o[2] === 1'b1) p_at = c;
            if (bus_b.press_o[2] === 1'b1) np_b++;
            if (bus_a.release_o[2] === 1'b1) released = 1;
            if (check_b) begin
                n_checks++;
                if (bus_b.repeat_o !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL norepeat_strobe c=%0d got=%b required=0000", c, bus_b.repeat_o);
                end
            end
            if (bus_a.repeat_o[2] === 1'b1) begin
                if (released) nrep_late++;
                n_checks++;
                if (last_rep < 0) begin
                    if (c - p_at != RD * TD) begin
                        n_fail++;
                        $display("FAIL repeat_first_gap got=%0d clk required=%0d", c - p_at, RD * TD);
                    end
                end else if (c - last_rep != RP * TD) begin
                    n_fail++;
                    $display("FAIL repeat_period got=%0d clk required=%0d", c - last_rep, RP * TD);
                end
                last_rep = c;
                nrep++;
            end
        end
        n_checks++;
        if (nrep < 4 || nrep_late != 0) begin
            n_fail++;
            $display("FAIL repeat_count got=%0d (after release %0d) required>=4 (0)", nrep, nrep_late);
        end
        if (check_b) begin
            n_checks++;
            if (np_b != 1) begin
                n_fail++;
                $display("FAIL norepeat_press_count got=%0d required=1", np_b);
            end
        end
        $display("test_repeat%s: hold=%0d repeats=%0d", check_b ? "_disabled" : "", hold, nrep);
    endtask

    // ch0 and ch3 pressed in the same cycle.
    task automatic test_simultaneous();
        int d, n_any;
        bit seen;
        d = $urandom_range(0, 3);
        n_any = 0; seen = 0;
        for (int c = 0; c < d + 70; c++) begin
            btn = (c >= d && c < d + 40) ? 4'b0110 : 4'b1111;
            @(negedge clk);
            n_checks++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL simul_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
            end
            n_checks++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL simul_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
            end
            if (bus_a.any_press_o === 1'b1) n_any++;
            if (!seen && bus_a.press_o !== 4'b0000) begin
                seen = 1;
                n_checks++;
                if (bus_a.press_o !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL simul_press got=%b required=1001", bus_a.press_o);
                end
            end
        end
        n_checks++;
        if (n_any != 1) begin
            n_fail++;
            $display("FAIL simul_any_press_width got=%0d clk required=1", n_any);
        end
        $display("test_simultaneous: delay=%0d any_press_cycles=%0d", d, n_any);
    endtask

    // Independent random hold/release times on all channels.
    task automatic test_random();
        int left [4];
        logic [3:0] pins;
        pins = 4'b1111;
        for (int i = 0; i < 4; i++) left[i] = $urandom_range(1, 40);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    pins[i] = ~pins[i];
                    left[i] = $urandom_range(1, 40);
                end
            end
            btn = (c < 560) ? pins : 4'b1111;
            @(negedge clk);
            n_checks++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL random_model_a c=%0d got=%h expected=%h", c, act_a, exp_a);
            end
            n_checks++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL random_model_b c=%0d got=%h expected=%h", c, act_b, exp_b);
            end
        end
        $display("test_random: 600 cycles of random pin activity");
    endtask

    initial begin
        reset = 1'b1;
        btn   = 4'b1111;
        test_reset();
        test_glitch();
        test_clean_press();
        test_repeat(1'b0);
        test_simultaneous();
        test_repeat(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
